// File: rtl/sync_counter_n.sv
// Parametrised synchronous up/down counter with programmable modulus, load,
// clear, wrap/saturate mode, Gray mirror and terminal-count/wrap/overflow status.
module sync_counter_n #(
    parameter int WIDTH    = 3,
    parameter int MODULUS  = 8,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_gray,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    // MODULUS may equal 2^WIDTH, so the top value is derived before truncation.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ZERO    = WIDTH'(0);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] q_gray_q, q_gray_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic             at_max_s, at_min_s;

    assign at_max_s = (q_q == MAX_VAL);
    assign at_min_s = (q_q == ZERO);

    // Terminal count stays combinational so a cascaded stage can use it as carry-in.
    assign tc = en & ((up & at_max_s) | (~up & at_min_s));

    // Next-state logic: clear > load > en.
    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        ovf_d  = ovf_q;
        if (clear) begin
            q_d   = ZERO;
            ovf_d = 1'b0;
        end else if (load) begin
            if (load_val > MAX_VAL) begin
                q_d = MAX_VAL;
            end else begin
                q_d = load_val;
            end
        end else if (en) begin
            if (up) begin
                if (at_max_s) begin
                    ovf_d = 1'b1;
                    if (SATURATE != 0) begin
                        q_d = q_q;
                    end else begin
                        q_d    = ZERO;
                        wrap_d = 1'b1;
                    end
                end else begin
                    q_d = q_q + ONE;
                end
            end else begin
                if (at_min_s) begin
                    ovf_d = 1'b1;
                    if (SATURATE != 0) begin
                        q_d = q_q;
                    end else begin
                        q_d    = MAX_VAL;
                        wrap_d = 1'b1;
                    end
                end else begin
                    q_d = q_q - ONE;
                end
            end
        end else begin
            q_d = q_q;
        end
        q_gray_d = to_gray(q_d);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q      <= ZERO;
            q_gray_q <= ZERO;
            wrap_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            q_q      <= q_d;
            q_gray_q <= q_gray_d;
            wrap_q   <= wrap_d;
            ovf_q    <= ovf_d;
        end
    end

    assign q      = q_q;
    assign q_gray = q_gray_q;
    assign wrap   = wrap_q;
    assign ovf    = ovf_q;

endmodule

// File: doc/sync_counter_n.md
Name: sync_counter_n

Overview:
- Parametrised successor to the team's 3-bit T-flip-flop synchronous counter.
- Generalises the count to WIDTH bits with a programmable modulus, up/down direction, parallel load, synchronous clear, wrap or saturate mode, and a Gray-coded mirror output.
- Provides terminal-count, wrap-pulse and sticky overflow status for downstream timers, dividers and sequencers in the same clock domain.

Parameters:
- WIDTH, 3, counter width in bits (>=1).
- MODULUS, 8, count range is 0..MODULUS-1; legal range is 2..2^WIDTH.
- SATURATE, 0, 0 = wrap at the ends of the range, 1 = hold at the ends of the range.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- en  input  1  count enable; plays the role of the T input of the 3-bit counter.
- up  input  1  direction: 1 = increment, 0 = decrement.
- clear  input  1  synchronous clear of count and status.
- load  input  1  parallel load strobe.
- load_val  input  WIDTH  value to load.
- q  output  WIDTH  registered binary count.
- q_gray  output  WIDTH  registered Gray code of q (q ^ (q>>1)), updated in the same cycle as q.
- tc  output  1  combinational terminal count.
- wrap  output  1  registered one-cycle pulse.
- ovf  output  1  registered sticky overflow/underflow flag.

Behaviour:
- Single clock domain. Reset is synchronous and active-high on rst and is sampled only on the rising edge of clk.
- Reset values:
  - q = 0, q_gray = 0, wrap = 0, ovf = 0.
  - tc follows its equation from q = 0.
- Priority per edge, highest first: rst > clear > load > en. Lower-priority requests in the same cycle are ignored; none are queued.
- clear: q = 0, q_gray = 0, wrap = 0, ovf = 0.
- load:
  - If load_val <= MODULUS-1: q = load_val.
  - Otherwise q = MODULUS-1 (clamped).
  - wrap = 0. ovf is unchanged. Load does not require en.
- en = 1, up = 1:
  - q < MODULUS-1: q = q+1.
  - q == MODULUS-1 with SATURATE=0: q = 0, wrap = 1 next cycle, ovf = 1.
  - q == MODULUS-1 with SATURATE=1: q holds, ovf = 1, wrap stays 0.
- en = 1, up = 0:
  - q > 0: q = q-1.
  - q == 0 with SATURATE=0: q = MODULUS-1, wrap = 1, ovf = 1.
  - q == 0 with SATURATE=1: q holds, ovf = 1, wrap stays 0.
- en = 0: q holds, wrap = 0.
- wrap is high for exactly one cycle per wrap event. Consecutive wraps (e.g. MODULUS=2 counting continuously) give consecutive pulses.
- tc = en & ((up & q==MODULUS-1) | (~up & q==0)). It is combinational, so it is usable as a carry-enable into a cascaded stage in the same cycle.
- Width rules:
  - Comparisons use WIDTH-bit unsigned arithmetic.
  - For MODULUS = 2^WIDTH, natural rollover must equal the explicit wrap.
  - Never produce q >= MODULUS.
- Direction change takes effect on the next enabled edge, with no idle cycle.
- rst or clear asserted mid-count overrides everything on that edge. Counting resumes from 0 on the first edge after release.

Test Plan:
- Defaults, rst=1 for 12 ns then released, en=1, up=1 for 200 ns -> q steps 0..7 then 0 on successive edges; q_gray follows 000,001,011,010,110,111,101,100; wrap pulses once each time 7→0; ovf=1 after the first wrap; tc=1 only while q=7.
- MODULUS=6, SATURATE=0, up=0 from reset -> q = 5,4,3,2,1,0,5; wrap and ovf are set on the 0→5 transition; tc=1 while q=0.
- SATURATE=1, up=1, load load_val=6 then count -> q = 6,7,7,7; ovf=1 from the first held edge; wrap stays 0.
- MODULUS=6, load load_val=7 -> q = 5 (clamped). Then load=1 and en=1 in the same cycle with load_val=2 -> q = 2, no count step.
- Counting with ovf=1, assert clear and load together -> q = 0, ovf = 0, wrap = 0. Then assert rst while en=1 at q=4 -> q = 0 on that edge.
- en toggled 1,0,1 while up flips every cycle -> q holds on the en=0 cycle and each enabled edge moves ±1 per the current up; tc combinationally tracks en.
